// File: rtl/control_pipe.sv
// Control-generation stage: decodes one instruction per cycle into registered
// datapath strobes, holding loads in WAIT_MEM for MEM_LAT cycles and stopping at HALT.
module control_pipe #(
  parameter int INST_W  = 9,
  parameter int OP_W    = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [INST_W-1:0] Inst,
  input  logic              InstValid,
  input  logic              Stall,
  output logic              Accept,
  output logic              Busy,
  output logic              CtrlValid,
  output logic              Reg0Write,
  output logic              GenPurpRegWrite,
  output logic              WriteMem,
  output logic              Branch,
  output logic              MemToReg,
  output logic              Halt,
  output logic [OP_W-1:0]   OpOut
);

  typedef enum logic [1:0] {RUN, WAIT_MEM, HALTED} state_t;

  typedef struct packed {
    logic reg0;
    logic gpr;
    logic wmem;
    logic branch;
    logic m2r;
    logic halt;
  } ctrl_t;

  localparam ctrl_t LOAD_CTRL = '{reg0: 1'b1, gpr: 1'b1, wmem: 1'b0,
                                  branch: 1'b0, m2r: 1'b1, halt: 1'b0};

  state_t          state, state_n;
  logic [2:0]      cnt, cnt_n;
  ctrl_t           ctrl_q, ctrl_n, dec;
  logic            vld_q, vld_n;
  logic [OP_W-1:0] op, op_q, op_n;
  logic            is_load, is_halt;

  // Only the opcode field is decoded; the operand bits belong to the datapath.
  wire unused_inst = &{1'b0, Inst};

  function automatic ctrl_t decode(input logic [OP_W-1:0] o);
    ctrl_t c;
    c = '0;
    case (32'(o))
      0, 1, 2, 3, 4, 5, 6, 8: begin c.reg0 = 1'b1; c.gpr = 1'b1; end
      9, 10, 11, 12:          c.branch = 1'b1;
      13:                     c.wmem = 1'b1;
      14:                     c = LOAD_CTRL;
      15:                     c.halt = 1'b1;
      default:                ;
    endcase
    return c;
  endfunction

  assign op      = Inst[INST_W-1 -: OP_W];
  assign dec     = decode(op);
  assign is_load = (32'(op) == 14);
  assign is_halt = (32'(op) == 15);

  assign Accept = InstValid & ~Stall & (state == RUN);
  assign Busy   = (state == WAIT_MEM);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vld_n   = vld_q;
    ctrl_n  = ctrl_q;
    op_n    = op_q;
    if (!Stall) begin
      case (state)
        RUN: begin
          vld_n  = 1'b0;
          ctrl_n = '0;
          if (Accept) begin
            op_n = op;
            if (is_halt) begin
              vld_n   = 1'b1;
              ctrl_n  = dec;
              state_n = HALTED;
            end else if (is_load && MEM_LAT > 0) begin
              state_n = WAIT_MEM;
              cnt_n   = 3'(MEM_LAT);
            end else begin
              vld_n  = 1'b1;
              ctrl_n = dec;
            end
          end
        end
        WAIT_MEM: begin
          // The load is presented on the edge that drains the counter.
          cnt_n = cnt - 3'd1;
          if (cnt_n == 3'd0) begin
            vld_n   = 1'b1;
            ctrl_n  = LOAD_CTRL;
            state_n = RUN;
          end
        end
        HALTED: begin
          vld_n       = 1'b0;
          ctrl_n      = '0;
          ctrl_n.halt = 1'b1;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= RUN;
      cnt    <= 3'd0;
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      op_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      vld_q  <= vld_n;
      ctrl_q <= ctrl_n;
      op_q   <= op_n;
    end
  end

  assign CtrlValid       = vld_q;
  assign Reg0Write       = ctrl_q.reg0;
  assign GenPurpRegWrite = ctrl_q.gpr;
  assign WriteMem        = ctrl_q.wmem;
  assign Branch          = ctrl_q.branch;
  assign MemToReg        = ctrl_q.m2r;
  assign Halt            = ctrl_q.halt;
  assign OpOut           = op_q;

endmodule
